rx_stats_publish: RTL and testbench

Single-clock receive-statistics accumulator that counts good frames, good bytes and dropped frames, and publishes a coherent snapshot of all three counters at a fixed period. It sits directly upstream of the team's multi-bit clock-domain synchroniser. Between publishes the outputs are held constant, so every published word stays stable long enough for the synchroniser to carry it to the slower register/PCIe domain.

---
 rtl/rx_stats_publish.sv | 120 ++++++++++++
 tb/tb_rx_stats_publish.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_stats_publish.sv
// rx_stats_publish: counts good frames, good bytes and dropped frames, and publishes
// a coherent snapshot every PUB_PERIOD cycles; published words only move on publish edges.
module rx_stats_publish #(
    parameter int CNT_W      = 32,
    parameter int PUB_PERIOD = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stat_valid_i,
    input  logic             stat_good_i,
    input  logic [15:0]      stat_len_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] pub_pkts_o,
    output logic [CNT_W-1:0] pub_bytes_o,
    output logic [CNT_W-1:0] pub_drops_o,
    output logic [7:0]       pub_seq_o,
    output logic             pub_strobe_o
);

    localparam int               PER_W    = (PUB_PERIOD > 1) ? $clog2(PUB_PERIOD) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PUB_PERIOD - 1);

    // Stage 1: registered copy of the frame status.
    logic             s1_vld_q,  s1_vld_d;
    logic             s1_good_q, s1_good_d;
    logic [15:0]      s1_len_q,  s1_len_d;

    // Stage 2: live counters.
    logic [CNT_W-1:0] live_pkts_q,  live_pkts_d;
    logic [CNT_W-1:0] live_bytes_q, live_bytes_d;
    logic [CNT_W-1:0] live_drops_q, live_drops_d;

    // Publish side.
    logic [PER_W-1:0] per_cnt_q,   per_cnt_d;
    logic [CNT_W-1:0] pub_pkts_q,  pub_pkts_d;
    logic [CNT_W-1:0] pub_bytes_q, pub_bytes_d;
    logic [CNT_W-1:0] pub_drops_q, pub_drops_d;
    logic [7:0]       pub_seq_q,   pub_seq_d;
    logic             pub_stb_q,   pub_stb_d;
    logic             tick;

    always_comb begin
        s1_vld_d  = stat_valid_i;
        s1_good_d = stat_good_i;
        s1_len_d  = stat_len_i;
    end

    // clr wins over the stage-1 entry, which drops the frame sampled just before it.
    always_comb begin
        live_pkts_d  = live_pkts_q;
        live_bytes_d = live_bytes_q;
        live_drops_d = live_drops_q;
        if (clr_i) begin
            live_pkts_d  = '0;
            live_bytes_d = '0;
            live_drops_d = '0;
        end else if (s1_vld_q) begin
            if (s1_good_q) begin
                live_pkts_d  = live_pkts_q + 1'b1;
                live_bytes_d = live_bytes_q + CNT_W'(s1_len_q);
            end else begin
                live_drops_d = live_drops_q + 1'b1;
            end
        end
    end

    // The snapshot samples the pre-update live values, so a coincident clr is still reported.
    always_comb begin
        tick        = (per_cnt_q == PER_LAST);
        per_cnt_d   = tick ? '0 : per_cnt_q + 1'b1;
        pub_pkts_d  = pub_pkts_q;
        pub_bytes_d = pub_bytes_q;
        pub_drops_d = pub_drops_q;
        pub_seq_d   = pub_seq_q;
        pub_stb_d   = tick;
        if (tick) begin
            pub_pkts_d  = live_pkts_q;
            pub_bytes_d = live_bytes_q;
            pub_drops_d = live_drops_q;
            pub_seq_d   = pub_seq_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q     <= 1'b0;
            s1_good_q    <= 1'b0;
            s1_len_q     <= '0;
            live_pkts_q  <= '0;
            live_bytes_q <= '0;
            live_drops_q <= '0;
            per_cnt_q    <= '0;
            pub_pkts_q   <= '0;
            pub_bytes_q  <= '0;
            pub_drops_q  <= '0;
            pub_seq_q    <= '0;
            pub_stb_q    <= 1'b0;
        end else begin
            s1_vld_q     <= s1_vld_d;
            s1_good_q    <= s1_good_d;
            s1_len_q     <= s1_len_d;
            live_pkts_q  <= live_pkts_d;
            live_bytes_q <= live_bytes_d;
            live_drops_q <= live_drops_d;
            per_cnt_q    <= per_cnt_d;
            pub_pkts_q   <= pub_pkts_d;
            pub_bytes_q  <= pub_bytes_d;
            pub_drops_q  <= pub_drops_d;
            pub_seq_q    <= pub_seq_d;
            pub_stb_q    <= pub_stb_d;
        end
    end

    assign pub_pkts_o   = pub_pkts_q;
    assign pub_bytes_o  = pub_bytes_q;
    assign pub_drops_o  = pub_drops_q;
    assign pub_seq_o    = pub_seq_q;
    assign pub_strobe_o = pub_stb_q;

endmodule

// File: tb/tb_rx_stats_publish.sv
// Bench for rx_stats_publish: a PUB_PERIOD=16 instance with a scoreboard model,
// plus a CNT_W=8 / PUB_PERIOD=512 instance for counter wrap.
module tb_rx_stats_publish;

    localparam int P = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_vld, a_good, a_clr;
    logic [15:0] a_len;
    logic [31:0] a_pkts, a_bytes, a_drops;
    logic [7:0]  a_seq;
    logic        a_stb;

    logic        b_vld, b_good, b_clr;
    logic [15:0] b_len;
    logic [7:0]  b_pkts, b_bytes, b_drops;
    logic [7:0]  b_seq;
    logic        b_stb;

    rx_stats_publish #(.CNT_W(32), .PUB_PERIOD(P)) dut_a (
        .clk_i(clk), .rst_i(rst), .stat_valid_i(a_vld), .stat_good_i(a_good),
        .stat_len_i(a_len), .clr_i(a_clr), .pub_pkts_o(a_pkts), .pub_bytes_o(a_bytes),
        .pub_drops_o(a_drops), .pub_seq_o(a_seq), .pub_strobe_o(a_stb)
    );

    rx_stats_publish #(.CNT_W(8), .PUB_PERIOD(512)) dut_b (
        .clk_i(clk), .rst_i(rst), .stat_valid_i(b_vld), .stat_good_i(b_good),
        .stat_len_i(b_len), .clr_i(b_clr), .pub_pkts_o(b_pkts), .pub_bytes_o(b_bytes),
        .pub_drops_o(b_drops), .pub_seq_o(b_seq), .pub_strobe_o(b_stb)
    );

    typedef struct packed {
        logic [31:0] pkts;
        logic [31:0] bytes;
        logic [31:0] drops;
        logic [7:0]  seq;
    } snap_t;

    snap_t exp_q[$];
    snap_t exp;
    int    checks = 0;
    int    errors = 0;

    // Reference model state: edges since reset release, live counts, pending stage entry.
    int          e;
    logic [31:0] m_pkts, m_bytes, m_drops;
    logic [7:0]  m_seq;
    logic        p_vld, p_good;
    logic [15:0] p_len;
    bit          pub_now;

    task automatic model_reset();
        e = 0; m_pkts = 0; m_bytes = 0; m_drops = 0; m_seq = 0;
        p_vld = 0; p_good = 0; p_len = 0; pub_now = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_vld = 0; a_good = 0; a_len = 0; a_clr = 0;
        b_vld = 0; b_good = 0; b_len = 0; b_clr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Drives one cycle of stimulus on instance A and advances the model across that edge.
    task automatic drive_cycle(input bit v, input bit g, input logic [15:0] len, input bit c);
        a_vld = v; a_good = g; a_len = len; a_clr = c;
        @(posedge clk);
        e++;
        pub_now = ((e % P) == 0);
        if (pub_now) begin
            m_seq = m_seq + 8'd1;
            exp_q.push_back('{pkts: m_pkts, bytes: m_bytes, drops: m_drops, seq: m_seq});
        end
        if (c) begin
            m_pkts = 0; m_bytes = 0; m_drops = 0;
        end else if (p_vld) begin
            if (p_good) begin
                m_pkts  = m_pkts + 1;
                m_bytes = m_bytes + 32'(p_len);
            end else begin
                m_drops = m_drops + 1;
            end
        end
        p_vld = v; p_good = g; p_len = len;
        #1;
    endtask

    task automatic idle_until(input int target);
        while (e < target) drive_cycle(0, 0, 16'd0, 0);
    endtask

    task automatic advance_to_publish();
        do drive_cycle(0, 0, 16'd0, 0); while (!pub_now);
    endtask

    function automatic int next_pub();
        return ((e / P) + 1) * P;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_pkts, a_bytes, a_drops, a_seq, a_stb} !== 105'd0) begin
            errors++;
            $display("FAIL reset_a got pkts=%0d bytes=%0d drops=%0d seq=%0d stb=%0b want all 0",
                     a_pkts, a_bytes, a_drops, a_seq, a_stb);
        end
        checks++;
        if ({b_pkts, b_bytes, b_drops, b_seq, b_stb} !== 33'd0) begin
            errors++;
            $display("FAIL reset_b got pkts=%0d bytes=%0d drops=%0d seq=%0d stb=%0b want all 0",
                     b_pkts, b_bytes, b_drops, b_seq, b_stb);
        end
    endtask

    task automatic test_good_frames();
        do_reset();
        drive_cycle(0, 0, 16'd0, 0);
        drive_cycle(1, 1, 16'd64, 0);
        drive_cycle(1, 1, 16'd1500, 0);
        drive_cycle(1, 1, 16'd60, 0);
        idle_until(P - 1);
        checks++;
        if ({a_pkts, a_bytes, a_stb} !== 65'd0) begin
            errors++;
            $display("FAIL good_before_pub got pkts=%0d bytes=%0d stb=%0b want 0 0 0", a_pkts, a_bytes, a_stb);
        end
        drive_cycle(0, 0, 16'd0, 0);
        exp = exp_q.pop_front();
        checks++;
        if ({a_pkts, a_bytes, a_drops, a_seq, a_stb} !== {exp, 1'b1}) begin
            errors++;
            $display("FAIL good_sb got %0d/%0d/%0d seq=%0d stb=%0b want %0d/%0d/%0d seq=%0d stb=1",
                     a_pkts, a_bytes, a_drops, a_seq, a_stb, exp.pkts, exp.bytes, exp.drops, exp.seq);
        end
        checks++;
        if ({a_pkts, a_bytes, a_drops, a_seq} !== {32'd3, 32'd1624, 32'd0, 8'd1}) begin
            errors++;
            $display("FAIL good_lit got %0d/%0d/%0d seq=%0d want 3/1624/0 seq=1", a_pkts, a_bytes, a_drops, a_seq);
        end
        drive_cycle(0, 0, 16'd0, 0);
        checks++;
        if ({a_pkts, a_stb} !== {32'd3, 1'b0}) begin
            errors++;
            $display("FAIL strobe_one_cycle got pkts=%0d stb=%0b want 3 0", a_pkts, a_stb);
        end
    endtask

    task automatic test_bad_frames();
        drive_cycle(1, 0, 16'd100, 0);
        drive_cycle(1, 0, 16'd100, 0);
        advance_to_publish();
        exp = exp_q.pop_front();
        checks++;
        if ({a_pkts, a_bytes, a_drops, a_seq, a_stb} !== {exp, 1'b1}) begin
            errors++;
            $display("FAIL bad_sb got %0d/%0d/%0d seq=%0d want %0d/%0d/%0d seq=%0d",
                     a_pkts, a_bytes, a_drops, a_seq, exp.pkts, exp.bytes, exp.drops, exp.seq);
        end
        checks++;
        if ({a_pkts, a_bytes, a_drops, a_seq} !== {32'd3, 32'd1624, 32'd2, 8'd2}) begin
            errors++;
            $display("FAIL bad_lit got %0d/%0d/%0d seq=%0d want 3/1624/2 seq=2", a_pkts, a_bytes, a_drops, a_seq);
        end
    endtask

    task automatic test_snapshot_boundary();
        idle_until(next_pub() - 3);
        drive_cycle(1, 1, 16'd100, 0);
        drive_cycle(1, 1, 16'd100, 0);
        drive_cycle(0, 0, 16'd0, 0);
        exp = exp_q.pop_front();
        checks++;
        if ({a_pkts, a_bytes, a_drops, a_seq, a_stb} !== {exp, 1'b1}) begin
            errors++;
            $display("FAIL boundary_sb got %0d/%0d seq=%0d want %0d/%0d seq=%0d",
                     a_pkts, a_bytes, a_seq, exp.pkts, exp.bytes, exp.seq);
        end
        checks++;
        if ({a_pkts, a_bytes} !== {32'd4, 32'd1724}) begin
            errors++;
            $display("FAIL boundary_s got %0d/%0d want 4/1724", a_pkts, a_bytes);
        end
        advance_to_publish();
        exp = exp_q.pop_front();
        checks++;
        if ({a_pkts, a_bytes, a_drops, a_seq} !== {32'd5, 32'd1824, 32'd2, 8'd4}) begin
            errors++;
            $display("FAIL boundary_s16 got %0d/%0d/%0d seq=%0d want 5/1824/2 seq=4", a_pkts, a_bytes, a_drops, a_seq);
        end
    endtask

    task automatic test_clr();
        int held_bad = 0;
        idle_until(e + 4);
        drive_cycle(1, 1, 16'd300, 0);
        drive_cycle(1, 1, 16'd200, 1);
        while (!pub_now) begin
            drive_cycle(0, 0, 16'd0, 0);
            if (!pub_now && {a_pkts, a_bytes, a_drops, a_stb} !== {32'd5, 32'd1824, 32'd2, 1'b0}) held_bad++;
        end
        checks++;
        if (held_bad != 0) begin
            errors++;
            $display("FAIL clr_hold got %0d changed cycles want 0", held_bad);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({a_pkts, a_bytes, a_drops, a_seq, a_stb} !== {exp, 1'b1} ||
            {a_pkts, a_bytes, a_drops} !== {32'd1, 32'd200, 32'd0}) begin
            errors++;
            $display("FAIL clr_first got %0d/%0d/%0d seq=%0d want 1/200/0 seq=%0d",
                     a_pkts, a_bytes, a_drops, a_seq, exp.seq);
        end
        advance_to_publish();
        exp = exp_q.pop_front();
        checks++;
        if ({a_pkts, a_bytes, a_drops, a_seq} !== {32'd1, 32'd200, 32'd0, exp.seq}) begin
            errors++;
            $display("FAIL clr_second got %0d/%0d/%0d want 1/200/0", a_pkts, a_bytes, a_drops);
        end
        drive_cycle(1, 1, 16'd50, 0);
        idle_until(next_pub() - 1);
        drive_cycle(0, 0, 16'd0, 1);
        exp = exp_q.pop_front();
        checks++;
        if ({a_pkts, a_bytes, a_drops, a_seq, a_stb} !== {32'd2, 32'd250, 32'd0, exp.seq, 1'b1}) begin
            errors++;
            $display("FAIL clr_tick_pre got %0d/%0d/%0d stb=%0b want 2/250/0 stb=1", a_pkts, a_bytes, a_drops, a_stb);
        end
        advance_to_publish();
        exp = exp_q.pop_front();
        checks++;
        if ({a_pkts, a_bytes, a_drops} !== 96'd0) begin
            errors++;
            $display("FAIL clr_tick_post got %0d/%0d/%0d want 0/0/0", a_pkts, a_bytes, a_drops);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            b_vld = 1; b_good = 1; b_len = 16'd1;
            @(posedge clk); #1;
        end
        b_vld = 0; b_good = 0; b_len = 0;
        for (int i = 0; i < 700 && !b_stb; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (!b_stb) begin
            errors++;
            $display("FAIL wrap_timeout got no strobe want strobe within 700 cycles");
        end
        checks++;
        if ({b_pkts, b_bytes, b_drops, b_seq} !== {8'd44, 8'd44, 8'd0, 8'd1}) begin
            errors++;
            $display("FAIL wrap_vals got %0d/%0d/%0d seq=%0d want 44/44/0 seq=1", b_pkts, b_bytes, b_drops, b_seq);
        end
    endtask

    task automatic test_stability();
        logic [104:0] last;
        int pubs = 0;
        int bad_hold = 0;
        int bad_sb = 0;
        bit saw_wrap = 0;
        logic [7:0] prev_seq;
        do_reset();
        last = '0;
        prev_seq = 8'd0;
        for (int i = 0; i < P * 300 + 20 && pubs < 300; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                        16'($urandom), $urandom_range(0, 49) == 0);
            if (pub_now) begin
                pubs++;
                exp = exp_q.pop_front();
                if ({a_pkts, a_bytes, a_drops, a_seq, a_stb} !== {exp, 1'b1}) begin
                    bad_sb++;
                    if (bad_sb < 4)
                        $display("FAIL stab_sb got %0d/%0d/%0d seq=%0d want %0d/%0d/%0d seq=%0d",
                                 a_pkts, a_bytes, a_drops, a_seq, exp.pkts, exp.bytes, exp.drops, exp.seq);
                end
                if (prev_seq == 8'd255 && a_seq == 8'd0) saw_wrap = 1;
                prev_seq = a_seq;
            end else if ({a_pkts, a_bytes, a_drops, a_seq, a_stb} !== last) begin
                bad_hold++;
            end
            last = {a_pkts, a_bytes, a_drops, a_seq, 1'b0};
        end
        checks++;
        if (bad_sb != 0 || pubs != 300) begin
            errors++;
            $display("FAIL stab_scoreboard got %0d mismatches over %0d publishes want 0 over 300", bad_sb, pubs);
        end
        checks++;
        if (bad_hold != 0) begin
            errors++;
            $display("FAIL stab_hold got %0d off-strobe changes want 0", bad_hold);
        end
        checks++;
        if (!saw_wrap) begin
            errors++;
            $display("FAIL seq_wrap got no 255->0 transition want one");
        end
        idle_until(e + 5);
        drive_cycle(1, 1, 16'd500, 0);
        a_vld = 0; a_good = 0; a_len = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({a_pkts, a_bytes, a_drops, a_seq, a_stb} !== 105'd0) begin
            errors++;
            $display("FAIL midreset got %0d/%0d/%0d seq=%0d stb=%0b want all 0", a_pkts, a_bytes, a_drops, a_seq, a_stb);
        end
        rst = 1'b0;
        model_reset();
        advance_to_publish();
        exp = exp_q.pop_front();
        checks++;
        if ({a_pkts, a_bytes, a_drops, a_seq, a_stb} !== {96'd0, 8'd1, 1'b1} ||
            {a_pkts, a_bytes, a_drops, a_seq} !== exp) begin
            errors++;
            $display("FAIL midreset_lost got %0d/%0d/%0d seq=%0d want 0/0/0 seq=1", a_pkts, a_bytes, a_drops, a_seq);
        end
    endtask

    initial begin
        test_reset();
        test_good_frames();
        test_bad_frames();
        test_snapshot_boundary();
        test_clr();
        test_wrap();
        test_stability();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
